input_acc_mc: RTL and testbench

INPUT_ACC_MC -- requirements
Module: input_acc_mc

---
 rtl/input_acc_mc.sv | 157 +++++++++++++++
 tb/tb_input_acc_mc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_acc_mc.sv
// Multi-lane input accumulator FIFO with host/network write arbitration,
// one-cycle registered pop and an optional per-lane systolic output stagger.
module input_acc_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LANES  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [LANES-1:0]                     host_valid_in,
    input  logic [LANES*DATA_W-1:0]              host_data_in,
    input  logic [LANES-1:0]                     nn_valid_in,
    input  logic [LANES*DATA_W-1:0]              nn_data_in,
    input  logic                                 rd_valid_in,
    input  logic                                 skew_en_in,
    input  logic                                 clear_in,
    input  logic                                 err_clr_in,
    output logic [LANES-1:0]                     valid_out,
    output logic [LANES*DATA_W-1:0]              data_out,
    output logic [LANES*$clog2(DEPTH+1)-1:0]     count_out,
    output logic [LANES-1:0]                     full_out,
    output logic [LANES-1:0]                     empty_out,
    output logic                                 ovf_err_out,
    output logic                                 udf_err_out,
    output logic                                 drop_err_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [LANES-1:0] ovf_ev;
    logic [LANES-1:0] udf_ev;
    logic [LANES-1:0] drop_ev;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PW-1:0]     wr_ptr;
        logic [PW-1:0]     rd_ptr;
        logic [CW-1:0]     cnt;
        logic              pop_vld;
        logic [DATA_W-1:0] pop_data;

        logic [DATA_W-1:0] host_d;
        logic [DATA_W-1:0] nn_d;
        logic [DATA_W-1:0] wr_data_c;
        logic              pop_c;
        logic              wr_req_c;
        logic              wr_acc_c;
        logic [PW-1:0]     wr_ptr_nxt_c;
        logic [PW-1:0]     rd_ptr_nxt_c;

        assign host_d    = host_data_in[i*DATA_W +: DATA_W];
        assign nn_d      = nn_data_in[i*DATA_W +: DATA_W];
        // network feedback wins the write port over the host
        assign wr_data_c = nn_valid_in[i] ? nn_d : host_d;
        assign wr_req_c  = nn_valid_in[i] | host_valid_in[i];
        assign pop_c     = rd_valid_in & (cnt != '0) & ~clear_in;
        // a full lane still takes a write when it pops in the same cycle
        assign wr_acc_c  = wr_req_c & ~clear_in & ((cnt < CW'(DEPTH)) | pop_c);

        assign wr_ptr_nxt_c = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        assign rd_ptr_nxt_c = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

        assign ovf_ev[i]  = wr_req_c & ~clear_in & ~wr_acc_c;
        assign udf_ev[i]  = rd_valid_in & (cnt == '0) & ~clear_in;
        assign drop_ev[i] = nn_valid_in[i] & host_valid_in[i] & ~clear_in;

        assign count_out[i*CW +: CW] = cnt;
        assign full_out[i]           = (cnt == CW'(DEPTH));
        assign empty_out[i]          = (cnt == '0);

        // storage array, written only on accepted writes; contents not reset
        always_ff @(posedge clk) begin
            if (wr_acc_c) begin
                mem[wr_ptr] <= wr_data_c;
            end
        end

        // pointers, occupancy and the registered pop stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                pop_vld  <= 1'b0;
                pop_data <= '0;
            end else if (clear_in) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                pop_vld  <= 1'b0;
                pop_data <= '0;
            end else begin
                if (wr_acc_c) begin
                    wr_ptr <= wr_ptr_nxt_c;
                end
                if (pop_c) begin
                    rd_ptr   <= rd_ptr_nxt_c;
                    pop_data <= mem[rd_ptr];
                end
                pop_vld <= pop_c;
                case ({wr_acc_c, pop_c})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        if (i == 0) begin : g_noskew
            assign valid_out[i]                = pop_vld;
            assign data_out[i*DATA_W +: DATA_W] = pop_data;
        end else begin : g_skew
            logic              sk_vld  [i];
            logic [DATA_W-1:0] sk_data [i];

            // stagger pipe of depth i, advancing every cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) begin
                        sk_vld[k]  <= 1'b0;
                        sk_data[k] <= '0;
                    end
                end else if (clear_in) begin
                    for (int k = 0; k < i; k++) begin
                        sk_vld[k]  <= 1'b0;
                        sk_data[k] <= '0;
                    end
                end else begin
                    for (int k = i - 1; k > 0; k--) begin
                        sk_vld[k]  <= sk_vld[k-1];
                        sk_data[k] <= sk_data[k-1];
                    end
                    sk_vld[0]  <= pop_vld;
                    sk_data[0] <= pop_data;
                end
            end

            assign valid_out[i]                 = skew_en_in ? sk_vld[i-1]  : pop_vld;
            assign data_out[i*DATA_W +: DATA_W] = skew_en_in ? sk_data[i-1] : pop_data;
        end
    end

    // sticky error flags; a new event beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_out  <= 1'b0;
            udf_err_out  <= 1'b0;
            drop_err_out <= 1'b0;
        end else begin
            ovf_err_out  <= (ovf_err_out  & ~err_clr_in) | (|ovf_ev);
            udf_err_out  <= (udf_err_out  & ~err_clr_in) | (|udf_ev);
            drop_err_out <= (drop_err_out & ~err_clr_in) | (|drop_ev);
        end
    end

endmodule

// File: tb/tb_input_acc_mc.sv
// Self-checking bench for input_acc_mc: directed vector table, hand-written
// skew / async-reset sequences and randomized traffic against a queue model.
module tb_input_acc_mc;

    localparam int unsigned DW = 16;
    localparam int unsigned DP = 4;
    localparam int unsigned L  = 3;
    localparam int unsigned CW = $clog2(DP + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [L-1:0]      host_valid;
    logic [L*DW-1:0]   host_data;
    logic [L-1:0]      nn_valid;
    logic [L*DW-1:0]   nn_data;
    logic              rd_valid;
    logic              skew_en;
    logic              clear;
    logic              err_clr;
    logic [L-1:0]      valid_out;
    logic [L*DW-1:0]   data_out;
    logic [L*CW-1:0]   count_out;
    logic [L-1:0]      full_out;
    logic [L-1:0]      empty_out;
    logic              ovf_err;
    logic              udf_err;
    logic              drop_err;

    input_acc_mc #(.DATA_W(DW), .DEPTH(DP), .LANES(L)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_valid_in (host_valid),
        .host_data_in  (host_data),
        .nn_valid_in   (nn_valid),
        .nn_data_in    (nn_data),
        .rd_valid_in   (rd_valid),
        .skew_en_in    (skew_en),
        .clear_in      (clear),
        .err_clr_in    (err_clr),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .count_out     (count_out),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .ovf_err_out   (ovf_err),
        .udf_err_out   (udf_err),
        .drop_err_out  (drop_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model: per-lane list (head at index 0), pop-result history
    logic [DW-1:0] mbuf [L][DP];
    int            mcnt [L];
    logic          hv   [L][L];
    logic [DW-1:0] hd   [L][L];
    logic          m_ovf, m_udf, m_drop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            mcnt[i] = 0;
            for (int k = 0; k < L; k++) begin
                hv[i][k] = 1'b0;
                hd[i][k] = '0;
            end
        end
        m_ovf = 1'b0; m_udf = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_update();
        logic e_ovf, e_udf, e_drop, pop;
        logic [DW-1:0] w, d;
        e_ovf = 1'b0; e_udf = 1'b0; e_drop = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (clear) begin
                mcnt[i] = 0;
                for (int k = 0; k < L; k++) begin
                    hv[i][k] = 1'b0;
                    hd[i][k] = '0;
                end
            end else begin
                pop = rd_valid && (mcnt[i] > 0);
                w   = mbuf[i][0];
                if (rd_valid && mcnt[i] == 0) e_udf = 1'b1;
                if (pop) begin
                    for (int k = 0; k < DP - 1; k++) mbuf[i][k] = mbuf[i][k+1];
                    mcnt[i]--;
                end
                if (nn_valid[i] && host_valid[i]) e_drop = 1'b1;
                if (nn_valid[i] || host_valid[i]) begin
                    d = nn_valid[i] ? nn_data[i*DW +: DW] : host_data[i*DW +: DW];
                    if (mcnt[i] < DP) begin
                        mbuf[i][mcnt[i]] = d;
                        mcnt[i]++;
                    end else begin
                        e_ovf = 1'b1;
                    end
                end
                for (int k = L - 1; k > 0; k--) begin
                    hv[i][k] = hv[i][k-1];
                    hd[i][k] = hd[i][k-1];
                end
                hv[i][0] = pop;
                if (pop) hd[i][0] = w;
            end
        end
        m_ovf  = (m_ovf  && !err_clr) || e_ovf;
        m_udf  = (m_udf  && !err_clr) || e_udf;
        m_drop = (m_drop && !err_clr) || e_drop;
    endtask

    task automatic compare_model();
        for (int i = 0; i < L; i++) begin
            int dly;
            dly = skew_en ? i : 0;
            chk($sformatf("valid[%0d]", i), 32'(valid_out[i]), 32'(hv[i][dly]));
            chk($sformatf("data[%0d]", i),  32'(data_out[i*DW +: DW]), 32'(hd[i][dly]));
            chk($sformatf("count[%0d]", i), 32'(count_out[i*CW +: CW]), 32'(mcnt[i]));
            chk($sformatf("full[%0d]", i),  32'(full_out[i]), 32'(mcnt[i] == DP));
            chk($sformatf("empty[%0d]", i), 32'(empty_out[i]), 32'(mcnt[i] == 0));
        end
        chk("ovf_err",  32'(ovf_err),  32'(m_ovf));
        chk("udf_err",  32'(udf_err),  32'(m_udf));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
    endtask

    // one clock: model consumes current inputs, DUT sampled 1 time unit after the edge
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        host_valid = '0; nn_valid = '0; host_data = '0; nn_data = '0;
        rd_valid = 1'b0; clear = 1'b0; err_clr = 1'b0;
    endtask

    typedef struct packed {
        logic          hw;
        logic          nw;
        logic [DW-1:0] hdat;
        logic [DW-1:0] ndat;
        logic          rd;
        logic          clr;
        logic          eclr;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic          eo;
        logic          eu;
        logic          edr;
    } vec_t;

    vec_t tbl [21];

    initial begin
        // same stimulus on every lane, skew off; expected values are post-edge
        tbl[0]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0009, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h000A, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd4, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0004, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000A, 3'd0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000A, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000A, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7FFF, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF, 3'd1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 3'd2, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0};

        // reset state
        rst_n = 1'b0; skew_en = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int v = 0; v < 21; v++) begin
            host_valid = {L{tbl[v].hw}};
            nn_valid   = {L{tbl[v].nw}};
            host_data  = {L{tbl[v].hdat}};
            nn_data    = {L{tbl[v].ndat}};
            rd_valid   = tbl[v].rd;
            clear      = tbl[v].clr;
            err_clr    = tbl[v].eclr;
            step();
            for (int i = 0; i < L; i++) begin
                chk($sformatf("tbl%0d valid[%0d]", v, i), 32'(valid_out[i]), 32'(tbl[v].ev));
                chk($sformatf("tbl%0d data[%0d]", v, i), 32'(data_out[i*DW +: DW]), 32'(tbl[v].ed));
                chk($sformatf("tbl%0d count[%0d]", v, i), 32'(count_out[i*CW +: CW]), 32'(tbl[v].ec));
            end
            chk($sformatf("tbl%0d ovf", v),  32'(ovf_err),  32'(tbl[v].eo));
            chk($sformatf("tbl%0d udf", v),  32'(udf_err),  32'(tbl[v].eu));
            chk($sformatf("tbl%0d drop", v), 32'(drop_err), 32'(tbl[v].edr));
        end

        // skew: one word per lane, single pop, lanes surface at +1, +2, +3
        idle_inputs(); err_clr = 1'b1; clear = 1'b1;
        step();
        idle_inputs();
        host_valid = '1;
        host_data  = {16'h00CC, 16'h00BB, 16'h00AA};
        step();
        idle_inputs();
        skew_en = 1'b1; rd_valid = 1'b1;
        step();
        chk("skew +1", 32'(valid_out), 32'(3'b001));
        chk("skew +1 data0", 32'(data_out[0 +: DW]), 32'h00AA);
        rd_valid = 1'b0;
        step();
        chk("skew +2", 32'(valid_out), 32'(3'b010));
        chk("skew +2 data1", 32'(data_out[DW +: DW]), 32'h00BB);
        step();
        chk("skew +3", 32'(valid_out), 32'(3'b100));
        chk("skew +3 data2", 32'(data_out[2*DW +: DW]), 32'h00CC);
        step();
        chk("skew +4", 32'(valid_out), 32'(3'b000));
        chk("skew hold data2", 32'(data_out[2*DW +: DW]), 32'h00CC);
        skew_en = 1'b0;

        // async reset mid-stream with live valid and a set error flag
        idle_inputs();
        host_valid = '1; nn_valid = 3'b010;
        host_data = {16'h1111, 16'h2222, 16'h3333}; nn_data = {3{16'h4444}};
        step();
        idle_inputs(); host_valid = '1; rd_valid = 1'b1;
        host_data = {3{16'h5555}};
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset valid", 32'(valid_out), 32'h0);
        chk("areset data", 32'(data_out[31:0]), 32'h0);
        chk("areset count", 32'(count_out), 32'h0);
        chk("areset empty", 32'(empty_out), 32'(3'b111));
        chk("areset flags", 32'({ovf_err, udf_err, drop_err}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs(); host_valid = '1; host_data = {3{16'h0BEE}};
        step();
        chk("post-reset write", 32'(count_out[0 +: CW]), 32'd1);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            host_valid = L'($urandom);
            nn_valid   = ($urandom_range(0, 3) == 0) ? L'($urandom) : '0;
            host_data  = {$urandom, $urandom};
            nn_data    = {$urandom, $urandom};
            rd_valid   = ($urandom_range(0, 99) < 45);
            clear      = ($urandom_range(0, 59) == 0);
            err_clr    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 24) == 0) skew_en = ~skew_en;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
